pcie_status_led: RTL

//  Downstream of the ExaNIC X10 PCIe core: takes its error strobes and RQ/CC beat handshakes,

---
 rtl/pcie_status_led_pkg.sv | 15 +
 rtl/pcie_status_led_stretch.sv | 36 +++
 rtl/pcie_status_led.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/pcie_status_led_pkg.sv
// Shared fault FSM encodings and default timing constants
// for the PCIe status LED block.
package pcie_status_led_pkg;

  typedef enum logic [1:0] {
    FLT_CLEAR = 2'd0,
    FLT_ON    = 2'd1,
    FLT_OFF   = 2'd2
  } flt_state_e;

  localparam int DEF_STRETCH_CYCLES = 12500000;
  localparam int DEF_CNT_WIDTH      = 16;
  localparam int DEF_HB_CYCLES      = 125000000;

endpackage

// File: rtl/pcie_status_led_stretch.sv
// Pulse stretcher: one-cycle event -> STRETCH_CYCLES of LED on-time,
// retriggerable, registered output.
module led_pulse_stretch #(
  parameter int STRETCH_CYCLES = 12500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pulse_in,
  output logic led_out
);

  localparam int SW = $clog2(STRETCH_CYCLES + 1);
  localparam logic [SW-1:0] LOAD = SW'(STRETCH_CYCLES);

  logic [SW-1:0] r_cnt;
  logic          r_led;

  // Reload on every event, otherwise count down; LED tracks next count != 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_led <= 1'b0;
    end else if (pulse_in) begin
      r_cnt <= LOAD;
      r_led <= 1'b1;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - SW'(1);
      r_led <= (r_cnt > SW'(1));
    end else begin
      r_led <= 1'b0;
    end
  end

  assign led_out = r_led;

endmodule

// File: rtl/pcie_status_led.sv
// PCIe status LEDs, error counters and fault blinker.
// Optional heartbeat on sfp_2_led[0]: PCIE_STATUS_LED_HEARTBEAT_EN.
module pcie_status_led
  import pcie_status_led_pkg::*;
#(
  parameter int STRETCH_CYCLES = DEF_STRETCH_CYCLES,
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH
`ifdef PCIE_STATUS_LED_HEARTBEAT_EN
  ,
  parameter int HB_CYCLES      = DEF_HB_CYCLES
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 status_error_cor,
  input  logic                 status_error_uncor,
  input  logic                 rq_fire,
  input  logic                 cc_fire,
  input  logic                 cnt_clear,
  output logic [1:0]           sfp_1_led,
  output logic [1:0]           sfp_2_led,
  output logic [1:0]           sma_led,
  output logic [CNT_WIDTH-1:0] err_cor_count,
  output logic [CNT_WIDTH-1:0] err_uncor_count,
  output logic                 err_uncor_sticky
);

  localparam int TW =
    (STRETCH_CYCLES > 2) ? $clog2(STRETCH_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(STRETCH_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] C_ONE = CNT_WIDTH'(1);

  logic w_rq_led;
  logic w_cc_led;
  logic w_cor_led;
  logic w_hb_led;

  logic [CNT_WIDTH-1:0] r_cor_cnt;
  logic [CNT_WIDTH-1:0] r_uncor_cnt;
  logic                 r_sticky;
  flt_state_e           r_flt_state;
  logic [TW-1:0]        r_flt_timer;
  logic                 r_flt_led;

  led_pulse_stretch #(.STRETCH_CYCLES(STRETCH_CYCLES)) u_rq (
    .clk      (clk),
    .rst_n    (rst_n),
    .pulse_in (rq_fire),
    .led_out  (w_rq_led)
  );

  led_pulse_stretch #(.STRETCH_CYCLES(STRETCH_CYCLES)) u_cc (
    .clk      (clk),
    .rst_n    (rst_n),
    .pulse_in (cc_fire),
    .led_out  (w_cc_led)
  );

  led_pulse_stretch #(.STRETCH_CYCLES(STRETCH_CYCLES)) u_cor (
    .clk      (clk),
    .rst_n    (rst_n),
    .pulse_in (status_error_cor),
    .led_out  (w_cor_led)
  );

  // Saturating correctable-error counter; clear beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cor_cnt <= '0;
    end else if (cnt_clear) begin
      r_cor_cnt <= '0;
    end else if (status_error_cor && r_cor_cnt != '1) begin
      r_cor_cnt <= r_cor_cnt + C_ONE;
    end
  end

  // Saturating uncorrectable-error counter; clear beats increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_uncor_cnt <= '0;
    end else if (cnt_clear) begin
      r_uncor_cnt <= '0;
    end else if (status_error_uncor && r_uncor_cnt != '1) begin
      r_uncor_cnt <= r_uncor_cnt + C_ONE;
    end
  end

  // Sticky flag: first uncorrectable error latches until cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
    end else if (cnt_clear) begin
      r_sticky <= 1'b0;
    end else if (status_error_uncor) begin
      r_sticky <= 1'b1;
    end
  end

  // Fault blinker: on/off phases of STRETCH_CYCLES once a fault is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flt_state <= FLT_CLEAR;
      r_flt_timer <= '0;
      r_flt_led   <= 1'b0;
    end else if (cnt_clear) begin
      r_flt_state <= FLT_CLEAR;
      r_flt_timer <= '0;
      r_flt_led   <= 1'b0;
    end else begin
      unique case (r_flt_state)
        FLT_CLEAR: begin
          if (status_error_uncor) begin
            r_flt_state <= FLT_ON;
            r_flt_timer <= '0;
            r_flt_led   <= 1'b1;
          end
        end
        FLT_ON: begin
          if (r_flt_timer == T_LAST) begin
            r_flt_state <= FLT_OFF;
            r_flt_timer <= '0;
            r_flt_led   <= 1'b0;
          end else begin
            r_flt_timer <= r_flt_timer + TW'(1);
          end
        end
        FLT_OFF: begin
          if (r_flt_timer == T_LAST) begin
            r_flt_state <= FLT_ON;
            r_flt_timer <= '0;
            r_flt_led   <= 1'b1;
          end else begin
            r_flt_timer <= r_flt_timer + TW'(1);
          end
        end
        default: begin
          r_flt_state <= FLT_CLEAR;
          r_flt_timer <= '0;
          r_flt_led   <= 1'b0;
        end
      endcase
    end
  end

`ifdef PCIE_STATUS_LED_HEARTBEAT_EN
  localparam int HW =
    (HB_CYCLES > 2) ? $clog2(HB_CYCLES) : 1;
  localparam logic [HW-1:0] HB_LAST = HW'(HB_CYCLES - 1);

  logic [HW-1:0] r_hb_cnt;
  logic          r_hb_led;

  // Free-running heartbeat: toggle every HB_CYCLES cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hb_cnt <= '0;
      r_hb_led <= 1'b0;
    end else if (r_hb_cnt == HB_LAST) begin
      r_hb_cnt <= '0;
      r_hb_led <= ~r_hb_led;
    end else begin
      r_hb_cnt <= r_hb_cnt + HW'(1);
    end
  end

  assign w_hb_led = r_hb_led;
`else
  assign w_hb_led = 1'b0;
`endif

  assign sfp_1_led        = {w_cc_led, w_rq_led};
  assign sfp_2_led        = {1'b0, w_hb_led};
  assign sma_led          = {r_flt_led, w_cor_led};
  assign err_cor_count    = r_cor_cnt;
  assign err_uncor_count  = r_uncor_cnt;
  assign err_uncor_sticky = r_sticky;

endmodule
